// File: rtl/qpu_exu_oitf_param.sv
// Outstanding-instruction track FIFO for the QPU execution unit.
// Tracks in-flight long-pipe classical writebacks (rd index) and in-flight
// measurements (qubit list). Reports register and qubit hazards to dispatch.
// Optional macro QPU_OITF_FULL_BYPASS_EN lets a full FIFO accept an alloc
// in the same cycle as a retire.
module qpu_exu_oitf_param #(
    parameter int unsigned CF_DEPTH  = 4,
    parameter int unsigned MF_DEPTH  = 4,
    parameter int unsigned RFIDX_W   = 5,
    parameter int unsigned QUBIT_NUM = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dis_cl_ena,
    input  logic                            dis_qf_ena,
    output logic                            dis_cf_ready,
    output logic                            dis_mf_ready,
    input  logic                            ret_cl_ena,
    input  logic                            ret_qf_ena,
    output logic [RFIDX_W-1:0]              ret_rdidx,
    output logic                            ret_rdwen,
    output logic [QUBIT_NUM-1:0]            ret_mf,
    input  logic                            disp_i_rs1en,
    input  logic                            disp_i_rs2en,
    input  logic                            disp_i_rdwen,
    input  logic [RFIDX_W-1:0]              disp_i_rs1idx,
    input  logic [RFIDX_W-1:0]              disp_i_rs2idx,
    input  logic [RFIDX_W-1:0]              disp_i_rdidx,
    input  logic                            disp_i_qfren,
    input  logic [QUBIT_NUM-1:0]            disp_i_ql,
    output logic                            oitfrd_match_disprs1,
    output logic                            oitfrd_match_disprs2,
    output logic                            oitfrd_match_disprd,
    output logic                            oitfqf_match_dispql,
    output logic                            oitf_empty,
    output logic                            moitf_empty,
    output logic [$clog2(CF_DEPTH+1)-1:0]   cf_cnt,
    output logic [$clog2(MF_DEPTH+1)-1:0]   mf_cnt,
    output logic [1:0]                      proto_err
);

    localparam int unsigned CF_PTR_W = $clog2(CF_DEPTH);
    localparam int unsigned MF_PTR_W = $clog2(MF_DEPTH);
    localparam int unsigned CF_CNT_W = $clog2(CF_DEPTH+1);
    localparam int unsigned MF_CNT_W = $clog2(MF_DEPTH+1);

    logic [CF_PTR_W:0]     cf_wptr_q, cf_wptr_d, cf_rptr_q, cf_rptr_d;
    logic [CF_DEPTH-1:0]   cf_vld_q, cf_vld_d, cf_wen_q, cf_wen_d;
    logic [RFIDX_W-1:0]    cf_idx_q [CF_DEPTH];
    logic [RFIDX_W-1:0]    cf_idx_d [CF_DEPTH];
    logic [CF_CNT_W-1:0]   cf_cnt_q, cf_cnt_d;

    logic [MF_PTR_W:0]     mf_wptr_q, mf_wptr_d, mf_rptr_q, mf_rptr_d;
    logic [MF_DEPTH-1:0]   mf_vld_q, mf_vld_d;
    logic [QUBIT_NUM-1:0]  mf_ql_q [MF_DEPTH];
    logic [QUBIT_NUM-1:0]  mf_ql_d [MF_DEPTH];
    logic [MF_CNT_W-1:0]   mf_cnt_q, mf_cnt_d;

    logic [1:0]            perr_q, perr_d;

    logic cf_full, mf_full;
    logic cf_alloc, cf_ret, mf_alloc, mf_ret;

    // Full/empty from pointer index and wrap bit
    assign cf_full     = (cf_wptr_q[CF_PTR_W-1:0] == cf_rptr_q[CF_PTR_W-1:0]) &&
                         (cf_wptr_q[CF_PTR_W] != cf_rptr_q[CF_PTR_W]);
    assign mf_full     = (mf_wptr_q[MF_PTR_W-1:0] == mf_rptr_q[MF_PTR_W-1:0]) &&
                         (mf_wptr_q[MF_PTR_W] != mf_rptr_q[MF_PTR_W]);
    assign oitf_empty  = (cf_wptr_q == cf_rptr_q);
    assign moitf_empty = (mf_wptr_q == mf_rptr_q);

`ifdef QPU_OITF_FULL_BYPASS_EN
    assign dis_cf_ready = !cf_full || ret_cl_ena;
    assign dis_mf_ready = !mf_full || ret_qf_ena;
`else
    assign dis_cf_ready = !cf_full;
    assign dis_mf_ready = !mf_full;
`endif

    assign cf_alloc = dis_cl_ena && dis_cf_ready;
    assign cf_ret   = ret_cl_ena && !oitf_empty;
    assign mf_alloc = dis_qf_ena && dis_mf_ready;
    assign mf_ret   = ret_qf_ena && !moitf_empty;

    // Head entries presented to the return paths, zero when empty
    assign ret_rdidx = oitf_empty  ? '0   : cf_idx_q[cf_rptr_q[CF_PTR_W-1:0]];
    assign ret_rdwen = oitf_empty  ? 1'b0 : cf_wen_q[cf_rptr_q[CF_PTR_W-1:0]];
    assign ret_mf    = moitf_empty ? '0   : mf_ql_q[mf_rptr_q[MF_PTR_W-1:0]];

    assign cf_cnt    = cf_cnt_q;
    assign mf_cnt    = mf_cnt_q;
    assign proto_err = perr_q;

    // Hazard match against every valid entry, including one retiring now
    always_comb begin
        logic rs1_hit, rs2_hit, rd_hit;
        logic [QUBIT_NUM-1:0] ql_or;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        ql_or   = '0;
        for (int i = 0; i < CF_DEPTH; i++) begin
            if (cf_vld_q[i] && cf_wen_q[i]) begin
                if (cf_idx_q[i] == disp_i_rs1idx) rs1_hit = 1'b1;
                if (cf_idx_q[i] == disp_i_rs2idx) rs2_hit = 1'b1;
                if (cf_idx_q[i] == disp_i_rdidx)  rd_hit  = 1'b1;
            end
        end
        for (int j = 0; j < MF_DEPTH; j++) begin
            if (mf_vld_q[j]) ql_or = ql_or | mf_ql_q[j];
        end
        oitfrd_match_disprs1 = disp_i_rs1en && rs1_hit;
        oitfrd_match_disprs2 = disp_i_rs2en && rs2_hit;
        oitfrd_match_disprd  = disp_i_rdwen && rd_hit;
        oitfqf_match_dispql  = disp_i_qfren && (|(disp_i_ql & ql_or));
    end

    // Next state: retire clears head first so a bypassed alloc into the same slot wins
    always_comb begin
        cf_wptr_d = cf_wptr_q;
        cf_rptr_d = cf_rptr_q;
        cf_vld_d  = cf_vld_q;
        cf_wen_d  = cf_wen_q;
        cf_idx_d  = cf_idx_q;
        cf_cnt_d  = cf_cnt_q;
        mf_wptr_d = mf_wptr_q;
        mf_rptr_d = mf_rptr_q;
        mf_vld_d  = mf_vld_q;
        mf_ql_d   = mf_ql_q;
        mf_cnt_d  = mf_cnt_q;
        perr_d    = perr_q;

        if (cf_ret) begin
            cf_vld_d[cf_rptr_q[CF_PTR_W-1:0]] = 1'b0;
            cf_rptr_d = cf_rptr_q + (CF_PTR_W+1)'(1);
        end
        if (cf_alloc) begin
            cf_vld_d[cf_wptr_q[CF_PTR_W-1:0]] = 1'b1;
            cf_wen_d[cf_wptr_q[CF_PTR_W-1:0]] = disp_i_rdwen;
            cf_idx_d[cf_wptr_q[CF_PTR_W-1:0]] = disp_i_rdidx;
            cf_wptr_d = cf_wptr_q + (CF_PTR_W+1)'(1);
        end
        case ({cf_alloc, cf_ret})
            2'b10:   cf_cnt_d = cf_cnt_q + CF_CNT_W'(1);
            2'b01:   cf_cnt_d = cf_cnt_q - CF_CNT_W'(1);
            default: cf_cnt_d = cf_cnt_q;
        endcase

        if (mf_ret) begin
            mf_vld_d[mf_rptr_q[MF_PTR_W-1:0]] = 1'b0;
            mf_rptr_d = mf_rptr_q + (MF_PTR_W+1)'(1);
        end
        if (mf_alloc) begin
            mf_vld_d[mf_wptr_q[MF_PTR_W-1:0]] = 1'b1;
            mf_ql_d[mf_wptr_q[MF_PTR_W-1:0]]  = disp_i_ql;
            mf_wptr_d = mf_wptr_q + (MF_PTR_W+1)'(1);
        end
        case ({mf_alloc, mf_ret})
            2'b10:   mf_cnt_d = mf_cnt_q + MF_CNT_W'(1);
            2'b01:   mf_cnt_d = mf_cnt_q - MF_CNT_W'(1);
            default: mf_cnt_d = mf_cnt_q;
        endcase

        if ((dis_cl_ena && !dis_cf_ready) || (dis_qf_ena && !dis_mf_ready)) perr_d[0] = 1'b1;
        if ((ret_cl_ena && oitf_empty) || (ret_qf_ena && moitf_empty))      perr_d[1] = 1'b1;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cf_wptr_q <= '0;
            cf_rptr_q <= '0;
            cf_vld_q  <= '0;
            cf_wen_q  <= '0;
            cf_cnt_q  <= '0;
            mf_wptr_q <= '0;
            mf_rptr_q <= '0;
            mf_vld_q  <= '0;
            mf_cnt_q  <= '0;
            perr_q    <= '0;
            for (int i = 0; i < CF_DEPTH; i++) cf_idx_q[i] <= '0;
            for (int j = 0; j < MF_DEPTH; j++) mf_ql_q[j]  <= '0;
        end else begin
            cf_wptr_q <= cf_wptr_d;
            cf_rptr_q <= cf_rptr_d;
            cf_vld_q  <= cf_vld_d;
            cf_wen_q  <= cf_wen_d;
            cf_idx_q  <= cf_idx_d;
            cf_cnt_q  <= cf_cnt_d;
            mf_wptr_q <= mf_wptr_d;
            mf_rptr_q <= mf_rptr_d;
            mf_vld_q  <= mf_vld_d;
            mf_ql_q   <= mf_ql_d;
            mf_cnt_q  <= mf_cnt_d;
            perr_q    <= perr_d;
        end
    end

endmodule

// File: tb/tb_qpu_exu_oitf_param.sv
// Bench for qpu_exu_oitf_param: queue-based reference model, per-cycle compare,
// directed literal checks and a randomized phase.
module tb_qpu_exu_oitf_param;

    localparam int CF_DEPTH = 4;
    localparam int MF_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic dis_cl_ena, dis_qf_ena, ret_cl_ena, ret_qf_ena;
    logic dis_cf_ready, dis_mf_ready;
    logic [4:0] ret_rdidx;
    logic ret_rdwen;
    logic [7:0] ret_mf;
    logic disp_i_rs1en, disp_i_rs2en, disp_i_rdwen, disp_i_qfren;
    logic [4:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
    logic [7:0] disp_i_ql;
    logic m_rs1, m_rs2, m_rd, m_ql;
    logic oitf_empty, moitf_empty;
    logic [2:0] cf_cnt, mf_cnt;
    logic [1:0] proto_err;

    qpu_exu_oitf_param dut (
        .clk(clk), .rst_n(rst_n),
        .dis_cl_ena(dis_cl_ena), .dis_qf_ena(dis_qf_ena),
        .dis_cf_ready(dis_cf_ready), .dis_mf_ready(dis_mf_ready),
        .ret_cl_ena(ret_cl_ena), .ret_qf_ena(ret_qf_ena),
        .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen), .ret_mf(ret_mf),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rdwen(disp_i_rdwen),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rdidx(disp_i_rdidx),
        .disp_i_qfren(disp_i_qfren), .disp_i_ql(disp_i_ql),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
        .oitfrd_match_disprd(m_rd), .oitfqf_match_dispql(m_ql),
        .oitf_empty(oitf_empty), .moitf_empty(moitf_empty),
        .cf_cnt(cf_cnt), .mf_cnt(mf_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic wen; logic [4:0] idx; } ce_t;
    ce_t        cq[$];
    logic [7:0] mq[$];
    logic [1:0] perr;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

`ifdef QPU_OITF_FULL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit m_cready();
        return (cq.size() < CF_DEPTH) || (BYP && ret_cl_ena);
    endfunction
    function automatic bit m_mready();
        return (mq.size() < MF_DEPTH) || (BYP && ret_qf_ena);
    endfunction

    // Reference model advances on each rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            cq.delete();
            mq.delete();
            perr = 2'b00;
        end else begin
            bit cr, mr;
            ce_t e;
            cr = m_cready();
            mr = m_mready();
            if ((dis_cl_ena && !cr) || (dis_qf_ena && !mr)) perr[0] = 1'b1;
            if ((ret_cl_ena && cq.size() == 0) || (ret_qf_ena && mq.size() == 0)) perr[1] = 1'b1;
            if (ret_cl_ena && cq.size() > 0) void'(cq.pop_front());
            if (ret_qf_ena && mq.size() > 0) void'(mq.pop_front());
            if (dis_cl_ena && cr) begin
                e.wen = disp_i_rdwen;
                e.idx = disp_i_rdidx;
                cq.push_back(e);
            end
            if (dis_qf_ena && mr) mq.push_back(disp_i_ql);
        end
    end

    // Compare all outputs just before each rising edge
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            bit h1, h2, hd;
            logic [7:0] qor;
            h1 = 0; h2 = 0; hd = 0; qor = '0;
            foreach (cq[k]) if (cq[k].wen) begin
                if (cq[k].idx == disp_i_rs1idx) h1 = 1;
                if (cq[k].idx == disp_i_rs2idx) h2 = 1;
                if (cq[k].idx == disp_i_rdidx)  hd = 1;
            end
            foreach (mq[k]) qor = qor | mq[k];
            chk("cf_ready", dis_cf_ready, m_cready());
            chk("mf_ready", dis_mf_ready, m_mready());
            chk("oitf_empty", oitf_empty, cq.size() == 0);
            chk("moitf_empty", moitf_empty, mq.size() == 0);
            chk("cf_cnt", cf_cnt, cq.size());
            chk("mf_cnt", mf_cnt, mq.size());
            chk("ret_rdidx", ret_rdidx, cq.size() ? cq[0].idx : 5'd0);
            chk("ret_rdwen", ret_rdwen, cq.size() ? cq[0].wen : 1'b0);
            chk("ret_mf", ret_mf, mq.size() ? mq[0] : 8'd0);
            chk("match_rs1", m_rs1, disp_i_rs1en && h1);
            chk("match_rs2", m_rs2, disp_i_rs2en && h2);
            chk("match_rd", m_rd, disp_i_rdwen && hd);
            chk("match_ql", m_ql, disp_i_qfren && (|(disp_i_ql & qor)));
            chk("proto_err", proto_err, perr);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        dis_cl_ena = 0; dis_qf_ena = 0; ret_cl_ena = 0; ret_qf_ena = 0;
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rdwen = 0; disp_i_qfren = 0;
        disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rdidx = 0; disp_i_ql = 0;
    endtask

    initial begin
        int n;
        rst_n = 0;
        idle();
        tick();
        tick();
        chk_en = 1;
        rst_n = 1;
        tick();
        #1;
        chk("rst_empty", oitf_empty, 1);
        chk("rst_mempty", moitf_empty, 1);
        chk("rst_cready", dis_cf_ready, 1);
        chk("rst_mready", dis_mf_ready, 1);
        chk("rst_cnt", cf_cnt, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_rdidx", ret_rdidx, 0);

        // Two allocations, hazard checks, then retire
        dis_cl_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 5;
        tick();
        disp_i_rdwen = 0; disp_i_rdidx = 7;
        tick();
        dis_cl_ena = 0;
        disp_i_rs1en = 1; disp_i_rs1idx = 5; disp_i_rs2en = 1; disp_i_rs2idx = 7;
        #1;
        chk("d_rs1_hit", m_rs1, 1);
        chk("d_rs2_nohit", m_rs2, 0);
        chk("d_head5", ret_rdidx, 5);
        chk("d_cnt2", cf_cnt, 2);
        ret_cl_ena = 1;
        tick();
        ret_cl_ena = 0;
        #1;
        chk("d_rs1_drop", m_rs1, 0);
        chk("d_head7", ret_rdidx, 7);
        ret_cl_ena = 1;
        tick();
        idle();

        // Fill, overflow attempt, drain, wrap
        dis_cl_ena = 1; disp_i_rdwen = 1;
        for (int i = 0; i < 4; i++) begin
            disp_i_rdidx = 5'(i + 1);
            tick();
        end
        dis_cl_ena = 0;
        #1;
        chk("f_ready0", dis_cf_ready, 0);
        chk("f_cnt4", cf_cnt, 4);
        dis_cl_ena = 1; disp_i_rdidx = 9;
        tick();
        dis_cl_ena = 0;
        #1;
        chk("f_perr0", proto_err[0], 1);
        chk("f_cnt_stay", cf_cnt, 4);
        ret_cl_ena = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("f_order", ret_rdidx, i + 1);
            tick();
        end
        ret_cl_ena = 0; dis_cl_ena = 1;
        for (int i = 0; i < 3; i++) begin
            disp_i_rdidx = 5'(10 + i);
            tick();
        end
        dis_cl_ena = 0; ret_cl_ena = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("w_order", ret_rdidx, 10 + i);
            tick();
        end
        ret_cl_ena = 0;
        #1 chk("w_empty", oitf_empty, 1);

        // Full with simultaneous alloc and retire
        dis_cl_ena = 1;
        for (int i = 0; i < 4; i++) begin
            disp_i_rdidx = 5'(20 + i);
            tick();
        end
        disp_i_rdidx = 30; ret_cl_ena = 1;
        #1 chk("b_ready", dis_cf_ready, BYP);
        tick();
        dis_cl_ena = 0; ret_cl_ena = 0;
        #1;
        chk("b_cnt", cf_cnt, BYP ? 4 : 3);
        chk("b_head", ret_rdidx, 21);
        chk("b_perr0", proto_err[0], 1);
        n = BYP ? 4 : 3;
        ret_cl_ena = 1;
        for (int i = 0; i < n; i++) begin
            #1 chk("b_order", ret_rdidx, (i == 3) ? 30 : 21 + i);
            tick();
        end
        idle();

        // Measurement FIFO hazard and underflow
        dis_qf_ena = 1; disp_i_ql = 8'b0000_0110;
        tick();
        dis_qf_ena = 0; disp_i_qfren = 1; disp_i_ql = 8'b0000_0100;
        #1 chk("q_hit", m_ql, 1);
        disp_i_ql = 8'b1000_0000;
        #1 chk("q_nohit", m_ql, 0);
        ret_qf_ena = 1;
        #1 chk("q_head", ret_mf, 8'b0000_0110);
        tick();
        #1 chk("q_empty", moitf_empty, 1);
        tick();
        ret_qf_ena = 0;
        #1 chk("q_perr1", proto_err[1], 1);
        idle();

        // Reset with entries outstanding
        dis_cl_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 3;
        dis_qf_ena = 1; disp_i_ql = 8'h11;
        tick();
        tick();
        dis_qf_ena = 0;
        tick();
        dis_cl_ena = 0; disp_i_rdwen = 0;
        disp_i_rs1en = 1; disp_i_rs1idx = 3; disp_i_qfren = 1; disp_i_ql = 8'h01;
        #1 chk("r_pre_match", m_rs1, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("r_empty", oitf_empty, 1);
        chk("r_mempty", moitf_empty, 1);
        chk("r_cnt", cf_cnt, 0);
        chk("r_mcnt", mf_cnt, 0);
        chk("r_rs1", m_rs1, 0);
        chk("r_ql", m_ql, 0);
        chk("r_perr", proto_err, 0);
        idle();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 149) != 0);
            dis_cl_ena    = 1'($urandom_range(0, 1));
            dis_qf_ena    = 1'($urandom_range(0, 1));
            ret_cl_ena    = 1'($urandom_range(0, 2) == 0);
            ret_qf_ena    = 1'($urandom_range(0, 2) == 0);
            disp_i_rs1en  = 1'($urandom_range(0, 1));
            disp_i_rs2en  = 1'($urandom_range(0, 1));
            disp_i_rdwen  = 1'($urandom_range(0, 1));
            disp_i_qfren  = 1'($urandom_range(0, 1));
            disp_i_rs1idx = 5'($urandom_range(0, 7));
            disp_i_rs2idx = 5'($urandom_range(0, 7));
            disp_i_rdidx  = 5'($urandom_range(0, 7));
            disp_i_ql     = 8'($urandom & $urandom);
            tick();
        end
        rst_n = 1;
        idle();
        tick();
        #5;
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
